// File: rtl/step_pulse_monitor.sv
// step_pulse_monitor: decodes an asynchronous step/dir pulse train into a
// signed position, a windowed edge count and a measured step period.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset        synchronous active-low reset
//   step_in      asynchronous step input, rising edge = one step
//   dir_in       asynchronous direction, 1 = up, 0 = down
//   arm          single-cycle request to open a measurement window
//   expected     edges the window waits for, latched on accepted arm
//   position     signed step position, wraps modulo 2^32
//   edge_count   edges counted in the current or most recent window
//   period       clk cycles between the last two consecutive edges
//   period_valid period holds a fresh measurement
//   timeout      no edge seen for TIMEOUT cycles
//   busy         window armed and counting
//   done         one-cycle pulse when a window completes
module step_pulse_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        arm,
    input  logic [30:0] expected,
    output logic [31:0] position,
    output logic [30:0] edge_count,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        timeout,
    output logic        busy,
    output logic        done
);

    localparam int unsigned POS_W = 32;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned WIN_W = 31;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] step_sync_q, dir_sync_q;
    logic                   step_prev_q;

    logic [POS_W-1:0] position_q, position_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             timeout_q, timeout_d;
    logic             seen_q, seen_d;
    logic [WIN_W-1:0] edge_count_q, edge_count_d;
    logic [WIN_W-1:0] expected_q, expected_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic step_s;
    logic dir_s;
    logic step_edge;
    logic arm_accept;

    assign step_s     = step_sync_q[SYNC_STAGES-1];
    assign dir_s      = dir_sync_q[SYNC_STAGES-1];
    assign step_edge  = step_s & ~step_prev_q;
    assign arm_accept = (state_q == S_IDLE) && arm;

    // Position, period measurement and timeout
    always_comb begin
        position_d     = position_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        timeout_d      = timeout_q;
        seen_d         = seen_q;

        if (step_edge) begin
            position_d = dir_s ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));
            cnt_d      = CNT_W'(1);
            seen_d     = 1'b1;
            timeout_d  = 1'b0;
            // The first edge after reset or a stale gap only restarts timing.
            if (seen_q && !timeout_q) begin
                period_d       = cnt_q;
                period_valid_d = 1'b1;
            end
        end else begin
            if (cnt_q < TIMEOUT_C) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                timeout_d      = 1'b1;
                period_valid_d = 1'b0;
            end
        end
    end

    // Window edge counter and expected latch
    always_comb begin
        edge_count_d = edge_count_q;
        expected_d   = expected_q;
        if (arm_accept) begin
            edge_count_d = '0;
            expected_d   = expected;
        end else if ((state_q == S_COUNT) && step_edge) begin
            edge_count_d = edge_count_q + WIN_W'(1);
        end
    end

    // Window FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = (expected == '0) ? S_DONE : S_COUNT;
                end
            end
            S_COUNT: begin
                if (step_edge && ((edge_count_q + WIN_W'(1)) == expected_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Window FSM outputs, registered below
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            S_COUNT: busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchronizers and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_sync_q    <= '0;
            dir_sync_q     <= '0;
            step_prev_q    <= 1'b0;
            position_q     <= '0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            seen_q         <= 1'b0;
            edge_count_q   <= '0;
            expected_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            step_sync_q    <= {step_sync_q[SYNC_STAGES-2:0], step_in};
            dir_sync_q     <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
            step_prev_q    <= step_s;
            position_q     <= position_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
            seen_q         <= seen_d;
            edge_count_q   <= edge_count_d;
            expected_q     <= expected_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign position     = position_q;
    assign edge_count   = edge_count_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
